// File: rtl/tdm_mux.sv
// tdm_mux: round-robin time-division multiplexer for the reservoir input stage.
// Serialises N_CH parallel W-bit channels onto one registered stream. Each
// slot lasts HOLD enabled cycles; the channel sample is latched once at the
// first hold phase of its slot and held for the rest of the slot.
//
// Optional feature macro: TDM_MUX_MASK_EN
//   defined   -> ch_mask port exists; a masked slot outputs zero with
//                dout_valid low for its whole duration, timing unchanged.
//   undefined -> all channels are always active, no ch_mask port.
module tdm_mux #(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  parameter  int HOLD = 1,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_CH*W-1:0] din,
`ifdef TDM_MUX_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  output logic [W-1:0]      dout,
  output logic              dout_valid,
  output logic [SW-1:0]     slot,
  output logic              frame_start
);

  // Hold counter needs at least one bit even when HOLD is 1.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

  // Unflattened view of the input channels.
  logic [W-1:0] ch [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch[k] = din[k*W +: W];
  end

  // Sequencing state: which slot is being served and which hold phase of it.
  logic [SW-1:0] cur_slot;
  logic [SW-1:0] next_slot;
  logic [HW-1:0] cur_hold;
  logic [HW-1:0] next_hold;
  logic          phase0;
  logic          slot_end;

  // Sample selected for the current slot, and whether the slot carries data.
  logic [W-1:0]  sample_sel;
  logic          vld_next;

  // Output-stage registers.
  logic [W-1:0]  data_p0;
  logic          vld_p0;
  logic [SW-1:0] slot_p0;
  logic          frame_p0;

  // Decode where we are inside the slot.
  always_comb begin
    phase0   = (cur_hold == '0);
    slot_end = (cur_hold == LAST_HOLD);
  end

  // Next slot/hold position: wrap the hold phase, then step the slot round-robin.
  always_comb begin
    next_slot = cur_slot;
    next_hold = cur_hold;
    if (slot_end) begin
      next_hold = '0;
      next_slot = (cur_slot == LAST_SLOT) ? '0 : cur_slot + 1'b1;
    end else begin
      next_hold = cur_hold + 1'b1;
    end
  end

  // Slot/hold counters advance only on enabled cycles; a pause freezes the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_slot <= '0;
      cur_hold <= '0;
    end else if (en) begin
      cur_slot <= next_slot;
      cur_hold <= next_hold;
    end
  end

  // Channel select for the slot currently being served.
  always_comb begin
    sample_sel = ch[cur_slot];
  end

`ifdef TDM_MUX_MASK_EN
  // Mask decision for the slot, captured at its first hold phase so that a
  // mask change mid-slot only takes effect from the next slot.
  logic slot_active;

  // Remember whether the slot in progress was enabled when it started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_active <= 1'b0;
    end else if (en && phase0) begin
      slot_active <= ch_mask[cur_slot];
    end
  end

  // Live-ness of the sample emitted this cycle: fresh mask at phase 0, latched otherwise.
  always_comb begin
    vld_next = phase0 ? ch_mask[cur_slot] : slot_active;
  end
`else
  // Without masking every slot carries live data.
  always_comb begin
    vld_next = 1'b1;
  end
`endif

  // ---- stage p0: registered output sample, slot tag, valid and frame marker ----
  // Latch the sample once per slot; valid and frame marker follow the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0  <= '0;
      vld_p0   <= 1'b0;
      slot_p0  <= '0;
      frame_p0 <= 1'b0;
    end else if (en) begin
      if (phase0) begin
        data_p0 <= vld_next ? sample_sel : '0;
        slot_p0 <= cur_slot;
      end
      vld_p0   <= vld_next;
      frame_p0 <= phase0 && (cur_slot == '0);
    end else begin
      vld_p0   <= 1'b0;
      frame_p0 <= 1'b0;
    end
  end

  assign dout        = data_p0;
  assign dout_valid  = vld_p0;
  assign slot        = slot_p0;
  assign frame_start = frame_p0;

endmodule

// File: tb/tb_tdm_mux.sv
// tb_tdm_mux: randomized bench for tdm_mux. Three instances with different
// channel count / width / hold length run side by side against a reference
// model that derives slot and phase from a single enabled-cycle count.
module tb_tdm_mux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  logic [31:0] din_a = '0;  // N_CH=4, W=8,  HOLD=1
  logic [31:0] din_b = '0;  // N_CH=4, W=8,  HOLD=3
  logic [59:0] din_c = '0;  // N_CH=5, W=12, HOLD=1

  logic [7:0]  dout_a, dout_b;
  logic [11:0] dout_c;
  logic        vld_a, vld_b, vld_c;
  logic [1:0]  slot_a, slot_b;
  logic [2:0]  slot_c;
  logic        fs_a, fs_b, fs_c;

`ifdef TDM_MUX_MASK_EN
  logic [3:0] mask_a = 4'hF;
  logic [3:0] mask_b = 4'hF;
  logic [4:0] mask_c = 5'h1F;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tdm_mux #(.N_CH(4), .W(8), .HOLD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_a),
`ifdef TDM_MUX_MASK_EN
    .ch_mask(mask_a),
`endif
    .dout(dout_a), .dout_valid(vld_a), .slot(slot_a), .frame_start(fs_a)
  );

  tdm_mux #(.N_CH(4), .W(8), .HOLD(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_b),
`ifdef TDM_MUX_MASK_EN
    .ch_mask(mask_b),
`endif
    .dout(dout_b), .dout_valid(vld_b), .slot(slot_b), .frame_start(fs_b)
  );

  tdm_mux #(.N_CH(5), .W(12), .HOLD(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_c),
`ifdef TDM_MUX_MASK_EN
    .ch_mask(mask_c),
`endif
    .dout(dout_c), .dout_valid(vld_c), .slot(slot_c), .frame_start(fs_c)
  );

  // Reference model: position in the frame follows from the count of enabled
  // cycles since reset: slot = (cnt / HOLD) mod N_CH, phase = cnt mod HOLD.
  int          nch  [3] = '{4, 4, 5};
  int          hold [3] = '{1, 3, 1};
  int          cnt  [3] = '{0, 0, 0};
  logic [11:0] e_dout [3] = '{12'h0, 12'h0, 12'h0};
  logic        e_vld  [3] = '{1'b0, 1'b0, 1'b0};
  int          e_slot [3] = '{0, 0, 0};
  logic        e_fs   [3] = '{1'b0, 1'b0, 1'b0};
  logic        live   [3] = '{1'b0, 1'b0, 1'b0};
  int          m_s, m_ph;

  function automatic logic [11:0] chan(input int d, input int s);
    case (d)
      0:       return {4'h0, din_a[s*8 +: 8]};
      1:       return {4'h0, din_b[s*8 +: 8]};
      default: return din_c[s*12 +: 12];
    endcase
  endfunction

  function automatic logic mask_bit(input int d, input int s);
`ifdef TDM_MUX_MASK_EN
    case (d)
      0:       return mask_a[s];
      1:       return mask_b[s];
      default: return mask_c[s];
    endcase
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        cnt[d]    = 0;
        e_dout[d] = '0;
        e_vld[d]  = 1'b0;
        e_slot[d] = 0;
        e_fs[d]   = 1'b0;
        live[d]   = 1'b0;
      end else if (!en) begin
        e_vld[d] = 1'b0;
        e_fs[d]  = 1'b0;
      end else begin
        m_s  = (cnt[d] / hold[d]) % nch[d];
        m_ph = cnt[d] % hold[d];
        if (m_ph == 0) begin
          live[d]   = mask_bit(d, m_s);
          e_slot[d] = m_s;
          e_dout[d] = live[d] ? chan(d, m_s) : 12'h0;
        end
        e_vld[d] = live[d];
        e_fs[d]  = (m_s == 0) && (m_ph == 0);
        cnt[d]   = cnt[d] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    check_eq("a.dout", 32'(dout_a), 32'(e_dout[0]));
    check_eq("a.vld",  32'(vld_a),  32'(e_vld[0]));
    check_eq("a.slot", 32'(slot_a), 32'(e_slot[0]));
    check_eq("a.fs",   32'(fs_a),   32'(e_fs[0]));
    check_eq("b.dout", 32'(dout_b), 32'(e_dout[1]));
    check_eq("b.vld",  32'(vld_b),  32'(e_vld[1]));
    check_eq("b.slot", 32'(slot_b), 32'(e_slot[1]));
    check_eq("b.fs",   32'(fs_b),   32'(e_fs[1]));
    check_eq("c.dout", 32'(dout_c), 32'(e_dout[2]));
    check_eq("c.vld",  32'(vld_c),  32'(e_vld[2]));
    check_eq("c.slot", 32'(slot_c), 32'(e_slot[2]));
    check_eq("c.fs",   32'(fs_c),   32'(e_fs[2]));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".outs_a"}, {20'h0, dout_a, vld_a, slot_a, fs_a}, 32'h0);
    check_eq({tag, ".outs_b"}, {20'h0, dout_b, vld_b, slot_b, fs_b}, 32'h0);
    check_eq({tag, ".outs_c"}, {15'h0, dout_c, vld_c, slot_c, fs_c}, 32'h0);
  endtask

  task automatic drive_random(input int en_pct);
    en    = ($urandom_range(0, 99) < en_pct);
    din_a = $urandom;
    din_b = $urandom;
    din_c = 60'({$urandom, $urandom});
`ifdef TDM_MUX_MASK_EN
    if ($urandom_range(0, 15) == 0) begin
      mask_a = 4'($urandom);
      mask_b = 4'($urandom);
      mask_c = 5'($urandom);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_seq  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [1:0] exp_slot [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_fs   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int         guard;

    // Reset held with random data and enable: all outputs stay at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all_zero("reset");
      drive_random(100);
    end

    // Release with a fixed pattern on instance a.
    @(negedge clk);
    en    = 1'b1;
    din_a = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef TDM_MUX_MASK_EN
    mask_a = 4'hF;
    mask_b = 4'hF;
    mask_c = 5'h1F;
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      compare_all();
      if (i < 5) begin
        check_eq("rel.dout", 32'(dout_a), 32'(exp_seq[i]));
        check_eq("rel.slot", 32'(slot_a), 32'(exp_slot[i]));
        check_eq("rel.fs",   32'(fs_a),   32'(exp_fs[i]));
        check_eq("rel.vld",  32'(vld_a),  32'h1);
      end
    end

    // Randomized data, enable gaps and mask changes.
    for (int i = 0; i < 400; i++) begin
      drive_random(80);
      @(negedge clk);
      compare_all();
    end

    // Run instance a to slot 3, then assert reset between edges.
    en    = 1'b1;
    guard = 0;
    while (e_slot[0] != 3 && guard < 8) begin
      @(negedge clk);
      compare_all();
      guard++;
    end
    check_eq("reach.slot3", 32'(slot_a), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    compare_all();
    @(negedge clk);
    check_all_zero("rst_held");
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    compare_all();
    check_eq("restart.slot", 32'(slot_a), 32'd0);
    check_eq("restart.fs",   32'(fs_a),   32'd1);
    check_eq("restart.c.fs", 32'(fs_c),   32'd1);

    for (int i = 0; i < 100; i++) begin
      drive_random(90);
      @(negedge clk);
      compare_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tdm_mux.md
# tdm_mux

Parametrised time-division multiplexer for the delay-line reservoir input stage. It serialises `N_CH` parallel `W`-bit channels onto one output stream in fixed round-robin slots, each slot lasting `HOLD` clock cycles. It generalises the single-bit, clock-phase-selected two-input mux to a counter-driven N-way selector with sample-and-hold, slot tagging and frame marking. It sits between the input-mask/feature stage and the nonlinear node.

## Interface
- `N_CH`, 4 — number of input channels; legal range ≥2.
- `W`, 8 — data width per channel.
- `HOLD`, 1 — clock cycles per slot (node duration θ); legal range ≥1.
- `SW`, `$clog2(N_CH)` — slot index width; derived, not overridden.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `en` input 1 — advance enable.
- `din` input `N_CH*W` — flattened channels; channel k is `din[k*W +: W]`.
- `ch_mask` input `N_CH` — per-channel enable (1 = active); present only with `TDM_MUX_MASK_EN`.
- `dout` output `W` — serialised sample, registered.
- `dout_valid` output 1 — `dout` carries a live slot.
- `slot` output `SW` — channel index of the sample on `dout`.
- `frame_start` output 1 — high while `dout` shows slot 0, hold phase 0.

## Operation
- Internal state: `cur_slot` (0..N_CH-1) and `cur_hold` (0..HOLD-1).
- Reset (async assert): `cur_slot`=0, `cur_hold`=0, `dout`=0, `dout_valid`=0, `slot`=0, `frame_start`=0. Release is synchronous to `clk`; the first active edge after release with `en`=1 emits slot 0.
- Each rising edge with `en`=1:
  - If `cur_hold`==0: `dout`←`din[cur_slot]`, `slot`←`cur_slot`. The sample is latched once per slot and held constant for `HOLD` cycles.
  - `dout_valid`←1. `frame_start`←(`cur_slot`==0 && `cur_hold`==0).
  - Advance: if `cur_hold`==HOLD-1, then `cur_hold`←0 and `cur_slot`←(`cur_slot`==N_CH-1 ? 0 : `cur_slot`+1); otherwise `cur_hold`++.
- Each rising edge with `en`=0: counters frozen, `dout`/`slot` hold, `dout_valid`←0, `frame_start`←0. Resuming continues from the frozen phase; the slot is not restarted and not resampled mid-slot.
- `din` changes during hold phases 1..HOLD-1 do not affect `dout`.
- `HOLD`=1: a new slot every enabled cycle, with `frame_start` every N_CH enabled cycles.
- No back-pressure; the consumer must accept every valid cycle.

## Timing
- Latency 1 cycle: `din` sampled at edge t appears on `dout` after edge t.
- Frame period `N_CH*HOLD` enabled cycles; `frame_start` is a 1-cycle pulse per frame (for `HOLD`>1 it marks only the first cycle of slot 0).
- Slot wrap N_CH-1→0 happens on the same edge that ends the last hold phase, with no idle cycle.
- Reset asserted mid-frame: outputs clear immediately (asynchronously), with no partial frame completion.

## Configuration
- `TDM_MUX_MASK_EN` defined: `ch_mask` port exists. At hold phase 0 of a slot whose `ch_mask` bit is 0, `dout`←0 and `dout_valid`←0 for all `HOLD` cycles of that slot. The slot still occupies its time and `slot` still updates, so frame timing is unchanged. `frame_start` is unaffected by the mask. A mask change takes effect at the next slot's hold phase 0.
- Not defined: no `ch_mask` port; all channels are always active.

## Test plan
- Reset/release: hold `rst_n`=0 with random `din` → all outputs 0. Release with `en`=1, N_CH=4, W=8, HOLD=1, `din`={8'h44,8'h33,8'h22,8'h11} → `dout` sequence 11,22,33,44,11…; `slot` 0,1,2,3,0; `frame_start` high on the 1st and 5th cycles.
- Hold: HOLD=3 → each value held 3 cycles. Toggling `din[0]` to 8'hAA during hold phase 1 → `dout` stays 11 until the next frame, then shows AA.
- Enable gap: deassert `en` for 2 cycles while `slot`=2, hold phase 1 of 3 → `dout_valid`=0 and `dout` held. On resume, 2 more cycles of slot 2, then slot 3.
- Async reset mid-frame: assert `rst_n` between edges at `slot`=3 → outputs 0 before the next edge. After release the sequence restarts at slot 0 with `frame_start`=1.
- Mask (`TDM_MUX_MASK_EN`): `ch_mask`=4'b1010, HOLD=2 → slots 0 and 2 give `dout`=0 and `dout_valid`=0 for 2 cycles each. Slots 1 and 3 are valid with 22 and 44; the frame length stays 8 cycles.
- Width/count sweep: N_CH=5, W=12, HOLD=1 → `slot` wraps 4→0 with no gap. `dout` matches `din[k*12 +: 12]` on every cycle over 3 frames.
